// File: rtl/relu_stream.sv
// Two-stage activation pipeline: bypass / ReLU / leaky ReLU / ReLU-N.
// Config rides with each beat; zeroed lanes feed a saturating counter.
module relu_stream #(
    parameter int NUM_WIDTH   = 16,
    parameter int CHANNELS    = 4,
    parameter int SHIFT_WIDTH = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    cfg_mode,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
    input  logic [NUM_WIDTH-1:0]          cfg_clamp,
    input  logic                          cnt_clear,
    input  logic [CHANNELS*NUM_WIDTH-1:0] up_data,
    input  logic                          up_valid,
    output logic                          up_ready,
    output logic [CHANNELS*NUM_WIDTH-1:0] dn_data,
    output logic                          dn_valid,
    input  logic                          dn_ready,
    output logic [CNT_WIDTH-1:0]          zero_count
);

    localparam int DW  = CHANNELS * NUM_WIDTH;
    localparam int NNW = $clog2(CHANNELS + 1);
    localparam int CW1 = CNT_WIDTH + 1;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RELU   = 2'd1,
        MODE_LEAKY  = 2'd2,
        MODE_CLAMP  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [DW-1:0]          data;
        mode_e                  mode;
        logic [SHIFT_WIDTH-1:0] shift;
        logic [NUM_WIDTH-1:0]   clamp;
    } s1_t;

    logic                 v1_q, v1_d;
    s1_t                  s1_q, s1_d;
    logic                 dv_q, dv_d;
    logic [DW-1:0]        dd_q, dd_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic adv1;
    logic adv2;

    logic signed [NUM_WIDTH-1:0] x_lane [CHANNELS];
    logic signed [NUM_WIDTH-1:0] y_lane [CHANNELS];
    logic signed [NUM_WIDTH-1:0] clamp_s;
    logic [DW-1:0]               act;
    logic [NNW-1:0]              nneg;
    logic                        counts;
    logic [CW1-1:0]              sum;

    assign adv2     = !dv_q || dn_ready;
    assign adv1     = !v1_q || adv2;
    assign up_ready = adv1;

    always_comb begin
        v1_d = v1_q;
        s1_d = s1_q;
        if (up_valid && adv1) begin
            v1_d       = 1'b1;
            s1_d.data  = up_data;
            s1_d.mode  = mode_e'(cfg_mode);
            s1_d.shift = cfg_shift;
            s1_d.clamp = cfg_clamp;
        end else if (adv2) begin
            v1_d = 1'b0;
        end
    end

    assign clamp_s = signed'(s1_q.clamp);
    assign counts  = (s1_q.mode == MODE_RELU)
                  || (s1_q.mode == MODE_CLAMP);

    always_comb begin
        act  = '0;
        nneg = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            x_lane[i] = signed'(s1_q.data[i*NUM_WIDTH +: NUM_WIDTH]);
            y_lane[i] = x_lane[i];
            case (s1_q.mode)
                MODE_RELU: begin
                    if (x_lane[i] < 0)
                        y_lane[i] = '0;
                end
                MODE_LEAKY: begin
                    if (x_lane[i] < 0)
                        y_lane[i] = x_lane[i] >>> s1_q.shift;
                end
                MODE_CLAMP: begin
                    if (x_lane[i] < 0)
                        y_lane[i] = '0;
                    else if (x_lane[i] > clamp_s)
                        y_lane[i] = clamp_s;
                end
                default: y_lane[i] = x_lane[i];
            endcase
            if (counts && (x_lane[i] < 0))
                nneg = nneg + NNW'(1);
            act[i*NUM_WIDTH +: NUM_WIDTH] = y_lane[i];
        end
    end

    assign sum = {1'b0, cnt_q} + CW1'(nneg);

    always_comb begin
        dv_d  = dv_q;
        dd_d  = dd_q;
        cnt_d = cnt_q;
        if (adv2) begin
            dv_d = v1_q;
            if (v1_q)
                dd_d = act;
        end
        // clear wins over an increment landing on the same edge
        if (cnt_clear)
            cnt_d = '0;
        else if (adv2 && v1_q)
            cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            s1_q  <= '0;
            dv_q  <= 1'b0;
            dd_q  <= '0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            s1_q  <= s1_d;
            dv_q  <= dv_d;
            dd_q  <= dd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dn_valid   = dv_q;
    assign dn_data    = dd_q;
    assign zero_count = cnt_q;

endmodule

// File: tb/tb_relu_stream.sv
// Bench for relu_stream: directed cases plus randomized streaming
// against a queue-based arithmetic reference model.
module tb_relu_stream;

    localparam int NW = 16;
    localparam int CH = 4;
    localparam int SW = 4;
    localparam int DW = NW * CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [SW-1:0] cfg_shift = '0;
    logic [NW-1:0] cfg_clamp = '0;
    logic          cnt_clear = 1'b0;
    logic [DW-1:0] up_data = '0;
    logic          up_valid = 1'b0;
    logic          dn_ready = 1'b0;

    logic          up_ready, dn_valid;
    logic [DW-1:0] dn_data;
    logic [31:0]   zero_count;
    logic          up_ready4, dn_valid4;
    logic [DW-1:0] dn_data4;
    logic [3:0]    zero_count4;

    relu_stream #(.NUM_WIDTH(NW), .CHANNELS(CH),
                  .SHIFT_WIDTH(SW), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
        .cfg_clamp(cfg_clamp), .cnt_clear(cnt_clear),
        .up_data(up_data), .up_valid(up_valid),
        .up_ready(up_ready), .dn_data(dn_data),
        .dn_valid(dn_valid), .dn_ready(dn_ready),
        .zero_count(zero_count)
    );

    relu_stream #(.NUM_WIDTH(NW), .CHANNELS(CH),
                  .SHIFT_WIDTH(SW), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
        .cfg_clamp(cfg_clamp), .cnt_clear(cnt_clear),
        .up_data(up_data), .up_valid(up_valid),
        .up_ready(up_ready4), .dn_data(dn_data4),
        .dn_valid(dn_valid4), .dn_ready(dn_ready),
        .zero_count(zero_count4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            neg;
    } exp_t;

    exp_t          q[$];
    int            errs = 0;
    int            checks = 0;
    longint        mcnt = 0;
    int            mcnt4 = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [NW-1:0] ref_lane(input int x, input int mode,
                                               input int sh, input int cl);
        int y;
        int p;
        y = x;
        if (mode == 1 && x < 0) y = 0;
        if (mode == 2 && x < 0) begin
            p = 1 << sh;
            y = x / p;
            if (x % p != 0) y = y - 1;
        end
        if (mode == 3) y = (x < 0) ? 0 : ((x > cl) ? cl : x);
        return y[NW-1:0];
    endfunction

    function automatic exp_t model(input logic [DW-1:0] d, input int mode,
                                   input int sh, input int cl);
        exp_t          e;
        logic [NW-1:0] lv;
        int            x;
        e.data = '0;
        e.neg  = 0;
        for (int i = 0; i < CH; i++) begin
            lv = d[i*NW +: NW];
            x  = $signed(lv);
            e.data[i*NW +: NW] = ref_lane(x, mode, sh, cl);
            if (x < 0 && (mode == 1 || mode == 3)) e.neg++;
        end
        return e;
    endfunction

    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic [1:0] m, input logic [SW-1:0] s,
                        input logic [NW-1:0] c, input logic r,
                        input logic clr, output logic fired);
        logic [NW-1:0] cv;
        up_valid  = v;
        up_data   = d;
        cfg_mode  = m;
        cfg_shift = s;
        cfg_clamp = c;
        dn_ready  = r;
        cnt_clear = clr;
        #1;
        if (prev_stall) begin
            chk("hold_valid", dn_valid, 1);
            chk("hold_data", dn_data, prev_data);
        end
        chk("up_ready", up_ready, !(q.size() == 2 && !r));
        if (dn_valid && q.size() == 0) begin
            chk("stale_beat", dn_valid, 0);
        end else if (dn_valid && r) begin
            chk("dn_data", dn_data, q[0].data);
            mcnt += q[0].neg;
            if (mcnt > 64'hFFFF_FFFF) mcnt = 64'hFFFF_FFFF;
            mcnt4 += q[0].neg;
            if (mcnt4 > 15) mcnt4 = 15;
            void'(q.pop_front());
        end
        fired = v && up_ready;
        cv = c;
        if (fired) q.push_back(model(d, int'(m), int'(s), $signed(cv)));
        prev_stall = dn_valid && !r;
        prev_data  = dn_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic r);
        logic f;
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, r, 0, f);
    endtask

    task automatic drain(input string tag);
        logic f;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0 && !dn_valid) break;
            step(0, '0, 0, 0, 0, 1, 0, f);
        end
        chk(tag, q.size(), 0);
    endtask

    task automatic single(input string tag, input logic [DW-1:0] d,
                          input logic [1:0] m, input logic [SW-1:0] s,
                          input logic [NW-1:0] c, input logic [DW-1:0] expv);
        logic f;
        step(1, d, m, s, c, 1, 0, f);
        chk({tag, "_acc"}, f, 1);
        chk({tag, "_lat1"}, dn_valid, 0);
        step(0, '0, 0, 0, 0, 1, 0, f);
        chk({tag, "_lat2"}, dn_valid, 1);
        chk({tag, "_data"}, dn_data, expv);
        step(0, '0, 0, 0, 0, 1, 0, f);
        chk({tag, "_once"}, dn_valid, 0);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        logic [NW-1:0] l;
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 7))
                0: l = 16'h8000;
                1: l = 16'h7FFF;
                2: l = 16'h0000;
                3: l = 16'hFFFF;
                default: l = NW'($urandom);
            endcase
            d[i*NW +: NW] = l;
        end
        return d;
    endfunction

    initial begin
        logic          f;
        logic [1:0]    m;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [NW-1:0] c;
        logic          pend;
        bit            pat [4];
        int            cyc;
        int            sent;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dn_valid", dn_valid, 0);
        chk("rst_dn_data", dn_data, 0);
        chk("rst_zero_count", zero_count, 0);
        chk("rst_up_ready", up_ready, 1);
        chk("rst_zero_count4", zero_count4, 0);
        rst_n = 1'b1;

        single("relu", 64'h7FFF_0000_FFFF_8000, 2'd1, 0, 0,
               64'h7FFF_0000_0000_0000);
        chk("relu_cnt", zero_count, 2);
        single("leaky", 64'h000C_FFFD_FFFF_FFF8, 2'd2, 4'd2, 0,
               64'h000C_FFFF_FFFF_FFFE);
        chk("leaky_cnt", zero_count, 2);
        single("clamp", 64'h0064_0006_0003_FFFB, 2'd3, 0, 16'd6,
               64'h0006_0006_0003_0000);
        chk("clamp_cnt", zero_count, 3);
        single("bypass", 64'h0064_0006_0003_FFFB, 2'd0, 0, 16'd6,
               64'h0064_0006_0003_FFFB);
        chk("bypass_cnt", zero_count, 3);
        single("leaky15", 64'h0000_7FFF_8000_FFFF, 2'd2, 4'd15, 0,
               64'h0000_7FFF_FFFF_FFFF);
        chk("model_cnt", zero_count, mcnt);

        step(0, '0, 0, 0, 0, 1, 1, f);
        mcnt  = 0;
        mcnt4 = 0;
        chk("clr_cnt", zero_count, 0);
        chk("clr_cnt4", zero_count4, 0);
        for (int i = 0; i < 3; i++)
            step(1, 64'h8000_FFFF_FFFE_8001, 2'd1, 0, 0, 1, 0, f);
        step(1, 64'h0001_0000_FFFF_8000, 2'd1, 0, 0, 1, 0, f);
        drain("drain_pre_sat");
        chk("cnt4_14", zero_count4, 14);
        step(1, 64'h8000_FFFF_FFFE_8001, 2'd3, 0, 16'd9, 1, 0, f);
        drain("drain_sat");
        chk("cnt4_sat", zero_count4, 15);
        chk("cnt_18", zero_count, 18);
        chk("cnt4_model", zero_count4, mcnt4);

        step(1, 64'h8000_FFFF_FFFE_8001, 2'd1, 0, 0, 1, 0, f);
        step(0, '0, 0, 0, 0, 1, 1, f);
        if (q.size() > 0) q[0].neg = 0;
        mcnt  = 0;
        mcnt4 = 0;
        drain("drain_clr");
        chk("clr_prio", zero_count, 0);
        chk("clr_prio4", zero_count4, 0);
        single("clamp4", 64'h0005_0003_0002_FFF0, 2'd3, 0, 16'd4,
               64'h0004_0003_0002_0000);
        chk("cnt_after_clr", zero_count, 1);

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        cyc  = 0;
        sent = 0;
        m    = 2'd0;
        pend = 1'b0;
        d = '0; s = '0; c = '0;
        while (sent < 8 && cyc < 200) begin
            if (!pend) begin
                m = 2'((int'(m) + 1 + $urandom_range(0, 2)) % 4);
                d = rnd_data();
                s = SW'($urandom);
                c = NW'($urandom_range(0, 16'h7FFF));
                pend = 1'b1;
            end
            step(1, d, m, s, c, pat[cyc % 4], 0, f);
            if (f) begin
                pend = 1'b0;
                sent++;
            end
            cyc++;
        end
        chk("stream_sent", sent, 8);
        drain("drain_stream");
        chk("stream_cnt", zero_count, mcnt);

        cyc  = 0;
        pend = 1'b0;
        while (cyc < 300) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                m = 2'($urandom);
                d = rnd_data();
                s = SW'($urandom);
                c = NW'($urandom_range(0, 16'h7FFF));
                pend = 1'b1;
            end
            step(pend, d, m, s, c, 1'($urandom), 0, f);
            if (f) pend = 1'b0;
            cyc++;
        end
        drain("drain_rand");
        chk("rand_cnt", zero_count, mcnt);
        chk("rand_cnt4", zero_count4, mcnt4);

        step(1, rnd_data(), 2'd1, 0, 0, 0, 0, f);
        step(1, rnd_data(), 2'd3, 0, 16'd5, 0, 0, f);
        chk("inflight", q.size(), 2);
        rst_n = 1'b0;
        step(0, '0, 0, 0, 0, 0, 0, f);
        q.delete();
        prev_stall = 1'b0;
        mcnt  = 0;
        mcnt4 = 0;
        chk("mid_rst_dn_valid", dn_valid, 0);
        chk("mid_rst_up_ready", up_ready, 1);
        chk("mid_rst_cnt", zero_count, 0);
        chk("mid_rst_cnt4", zero_count4, 0);
        rst_n = 1'b1;
        idle(6, 1);
        chk("post_rst_idle", dn_valid, 0);
        chk("post_rst_cnt", zero_count, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/relu_stream.md
Name: relu_stream

Overview:
- Multi-channel, mode-selectable activation stage with valid/ready flow control.
- Sits between the accumulator/bias output and the pooling/write-back path.
- Processes CHANNELS lanes of signed fixed-point numbers per beat.
- Supports bypass, ReLU, leaky ReLU (arithmetic shift) and clamped ReLU (ReLU-N). Counts zeroed elements for sparsity statistics.

Parameters:
- NUM_WIDTH, 16, width of one signed two's-complement lane.
- CHANNELS, 4, number of parallel lanes per beat.
- SHIFT_WIDTH, 4, width of the leaky-ReLU shift amount.
- CNT_WIDTH, 32, width of the saturating zero counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous reset, active-low.
- cfg_mode  input  2  0=bypass, 1=relu, 2=leaky, 3=clamp; sampled per beat.
- cfg_shift  input  SHIFT_WIDTH  leaky divisor exponent; sampled per beat.
- cfg_clamp  input  NUM_WIDTH  clamp ceiling, treated as signed and must be ≥0; sampled per beat.
- cnt_clear  input  1  clears zero_count.
- up_data  input  CHANNELS*NUM_WIDTH  input lanes; lane i occupies bits [i*NUM_WIDTH +: NUM_WIDTH].
- up_valid  input  1  upstream beat valid.
- up_ready  output  1  block accepts a beat.
- dn_data  output  CHANNELS*NUM_WIDTH  result lanes.
- dn_valid  output  1  downstream beat valid.
- dn_ready  input  1  downstream accepts.
- zero_count  output  CNT_WIDTH  saturating count of output lanes forced to zero by relu/clamp modes.

Behaviour:
- Reset (rst_n low at clk edge): stage-1 valid=0, dn_valid=0, dn_data=0, zero_count=0. Stage-1 data and config registers are also cleared.
  - Reset mid-transfer drops all in-flight beats. No beat emerges afterwards.
- Pipeline: two register stages, latency exactly 2 cycles from an up handshake to dn_valid when unstalled.
  - Stage 1 registers up_data plus cfg_mode/cfg_shift/cfg_clamp. Config therefore travels with its beat; a config change never alters a beat already accepted.
  - Stage 2 computes the activation and registers the result into dn_data/dn_valid.
- Flow control:
  - adv2 = !dn_valid || dn_ready.
  - adv1 = !v1 || adv2.
  - up_ready = adv1 (combinational from dn_ready).
  - Stage 1 loads on up_valid && up_ready; otherwise v1 clears when adv2.
  - Stage 2 loads v1 when adv2.
  - dn_data/dn_valid hold stable while dn_valid && !dn_ready. No beat is lost or duplicated.
  - Full throughput: 1 beat/cycle when dn_ready is held high.
- Per-lane arithmetic, x signed NUM_WIDTH:
  - bypass: y=x.
  - relu: y = x<0 ? 0 : x.
  - leaky: y = x<0 ? (x >>> cfg_shift) : x. Arithmetic shift rounds toward −inf. Shift ≥ NUM_WIDTH-1 yields −1 for negative x.
  - clamp: y = x<0 ? 0 : (x>cfg_clamp ? cfg_clamp : x). The comparison is signed.
  - x=0 is non-negative and passes unchanged in all modes.
- zero_count:
  - Increments on a stage-2 load, by the number of lanes with x<0 when the beat's mode is relu or clamp. Range 0..CHANNELS.
  - Saturates at all-ones.
  - Bypass and leaky beats never count.
  - cnt_clear has priority over a simultaneous increment: result is 0.
  - Updates once per accepted beat, never during a stall.

Test Plan:
- NUM_WIDTH=16, CHANNELS=4, mode=relu, lanes {0x8000,0xFFFF,0x0000,0x7FFF}, dn_ready=1 → two cycles later dn_data lanes {0,0,0,0x7FFF}, dn_valid=1 for one cycle, zero_count=2.
- mode=leaky, shift=2, lanes {-8,-1,-3,12} → {-2,-1,-1,12}; zero_count unchanged.
- mode=clamp, clamp=6, lanes {-5,3,6,100} → {0,3,6,6}; zero_count +1. Same beat in mode=bypass → {-5,3,6,100}.
- Streaming 8 beats with dn_ready toggling 1,0,0,1,…:
  - every beat appears once, in order, with its own mode, while cfg_mode changes every beat;
  - dn_data holds while stalled;
  - up_ready=0 only when both stages are full and dn_ready=0.
- Reset asserted with two beats in flight → next cycle dn_valid=0, up_ready=1, zero_count=0; no stale beat appears afterwards.
- zero_count preset near saturation (CNT_WIDTH=4, count=14), relu beat with 4 negatives → count=15 (saturates). cnt_clear asserted together with an increment → 0.
